to_serial: RTL
==============

Name: to_serial

Overview:
- Per-channel serializer; the stage directly upstream of the deserializer in the modulation datapath.
- Accepts one NO_CH-wide word of BW_IN-bit samples over a valid/ready handshake.
- Emits each sample as NO_CYC = BW_IN/BW_OUT chunks of BW_OUT bits, LSB chunk first, one chunk per cycle, tagged by vld_out.
- A one-entry holding buffer allows back-to-back words with no bubble between them.

Parameters:
- NO_CH, 10, number of parallel channels.
- BW_IN, 8, width of each input sample; must be an integer multiple of BW_OUT.
- BW_OUT, 2, width of each emitted chunk per channel.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- vld_in  input  1  input word valid.
- rdy_in  output  1  block can accept a word this cycle.
- data_in  input  NO_CH x BW_IN  input word, packed [NO_CH-1:0][BW_IN-1:0].
- stall  input  1  freezes serialization while high.
- vld_out  output  1  data_out holds a valid chunk this cycle.
- data_out  output  NO_CH x BW_OUT  current chunk per channel, packed [NO_CH-1:0][BW_OUT-1:0].

Behaviour:
- Fixed: one clock (clk); reset rst is asynchronous and active-high.
- Derived values:
  - NO_CYC = BW_IN/BW_OUT.
  - CNTR_BW = max(1, clog2(NO_CYC)).
- State:
  - shift register sh[NO_CH][BW_IN].
  - chunk counter cnt[CNTR_BW].
  - busy flag (FSM: IDLE = !busy, SHIFT = busy).
  - holding buffer hb[NO_CH][BW_IN] and hb_vld.
- Reset (async): sh=0, cnt=0, busy=0, hb_vld=0, hb=0. Outputs during and after reset: vld_out=0, data_out=0, rdy_in=1.
- Reset mid-word: the partial word and the buffered word are discarded; there is no resumption.
- Handshake:
  - accept = vld_in & rdy_in.
  - rdy_in = !hb_vld, registered state only; there is no combinational path from vld_in.
  - data_in is sampled only on accept.
- Outputs:
  - data_out[i] = sh[i][BW_OUT-1:0].
  - vld_out = busy & !stall. This is the only combinational input-to-output path.
- advance = busy & !stall. On advance, sh shifts right by BW_OUT per channel and cnt increments.
- IDLE: accept loads sh = data_in, cnt = 0, busy = 1. The first chunk appears the cycle after the accept edge (latency 1).
- SHIFT, advance with cnt < NO_CYC-1: shift only. If accept occurs, hb = data_in and hb_vld = 1.
- SHIFT, advance with cnt == NO_CYC-1 (last chunk), checked in this priority order:
  1. hb_vld: sh = hb, cnt = 0, hb_vld = 0, stay busy.
  2. Else accept: sh = data_in, cnt = 0, stay busy.
  3. Else busy = 0, return to IDLE.
- Stall high:
  - sh, cnt and busy hold.
  - Accept into hb is still permitted if hb is empty.
  - Stall in IDLE has no effect except that vld_out stays 0.
- Throughput: with vld_in held high and stall low, vld_out stays high continuously and the chunk stream has no gaps.
- NO_CYC = 1: every advance is a last chunk; the block acts as a 2-deep register FIFO.
- The bit order matches the downstream deserializer: chunk k carries input bits [k*BW_OUT +: BW_OUT].

Optional Feature:
- Macro: TO_SERIAL_LAST_EN.
- Defined:
  - Adds output port last_out (1 bit) = vld_out & (cnt == NO_CYC-1); it marks the final chunk of each word.
  - Reset value 0.
- Undefined: port absent; all other behaviour identical.

Test Plan:
- Single word, NO_CH=2, BW_IN=8, BW_OUT=2. Accept ch0=0xB4, ch1=0x1B at cycle 0 -> vld_out high cycles 1-4; ch0 chunks 0,1,3,2; ch1 chunks 3,2,1,0; vld_out=0 at cycle 5; rdy_in high throughout.
- Back-to-back: vld_in held high with words 0xB4, 0xFF, 0x00 on ch0 -> 12 consecutive vld_out cycles, no gap; rdy_in low while hb full; chunks 0,1,3,2,3,3,3,3,0,0,0,0.
- Stall: assert stall for 3 cycles after the 2nd chunk of 0xB4 -> vld_out=0 and data_out held for those 3 cycles; remaining chunks 3,2 follow; total 4 valid chunks.
- Loopback: drive into the downstream deserializer with the same parameters -> its 8-bit output equals the original word on every channel for 16 random words.
- Async reset mid-word: assert rst between clk edges after chunk 2 -> vld_out, data_out and busy clear immediately; rdy_in=1; the next accepted word serializes from chunk 0.
- TO_SERIAL_LAST_EN defined: last_out pulses exactly on chunks 4, 8, 12 of the back-to-back test and is never high while vld_out=0.

Source files
------------

// File: rtl/to_serial_if.sv
// Handshake and data bundle for to_serial. The block is the slave; whoever feeds it is the master.
// last_out is present only when TO_SERIAL_LAST_EN is defined.
interface to_serial_if #(
    parameter int NO_CH  = 10,
    parameter int BW_IN  = 8,
    parameter int BW_OUT = 2
);
    // Handshake: a word moves on a rising edge where vld_in and rdy_in are both high.
    // rdy_in comes from registered state only. vld_out carries no backpressure,
    // so a chunk is consumed in every cycle where vld_out is high.
    logic                         vld_in;
    logic                         rdy_in;
    logic [NO_CH-1:0][BW_IN-1:0]  data_in;
    logic                         stall;
    logic                         vld_out;
    logic [NO_CH-1:0][BW_OUT-1:0] data_out;
    logic                         fsm_state;
`ifdef TO_SERIAL_LAST_EN
    logic                         last_out;
`endif

    modport master (
        output vld_in, data_in, stall,
        input  rdy_in, vld_out, data_out, fsm_state
`ifdef TO_SERIAL_LAST_EN
        , input last_out
`endif
    );

    modport slave (
        input  vld_in, data_in, stall,
        output rdy_in, vld_out, data_out, fsm_state
`ifdef TO_SERIAL_LAST_EN
        , output last_out
`endif
    );
endinterface

// File: rtl/to_serial.sv
// to_serial: per-channel serializer that emits BW_IN/BW_OUT chunks per word, LSB chunk first.
// A one-word holding buffer hides the reload bubble. Define TO_SERIAL_LAST_EN to get last_out.
module to_serial #(
    parameter int NO_CH  = 10,
    parameter int BW_IN  = 8,
    parameter int BW_OUT = 2
) (
    input logic        clk,
    input logic        rst,
    to_serial_if.slave bus
);
    localparam int NO_CYC  = BW_IN / BW_OUT;
    localparam int CNTR_BW = (NO_CYC > 1) ? $clog2(NO_CYC) : 1;
    localparam logic [CNTR_BW-1:0] LAST_CNT = CNTR_BW'(NO_CYC - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]                  state;
    logic [NO_CH-1:0][BW_IN-1:0] sh;
    logic [NO_CH-1:0][BW_IN-1:0] sh_shr;
    logic [NO_CH-1:0][BW_IN-1:0] hb;
    logic                        hb_vld;
    logic [CNTR_BW-1:0]          cnt;
    logic                        busy;
    logic                        accept;
    logic                        advance;
    logic                        last_chunk;

    assign busy       = (state == SHIFT);
    assign accept     = bus.vld_in & bus.rdy_in;
    assign advance    = busy & ~bus.stall;
    assign last_chunk = (cnt == LAST_CNT);

    assign bus.rdy_in    = ~hb_vld;
    assign bus.vld_out   = advance;
    assign bus.fsm_state = state;
`ifdef TO_SERIAL_LAST_EN
    assign bus.last_out  = advance & last_chunk;
`endif

    always_comb begin
        sh_shr       = '0;
        bus.data_out = '0;
        for (int i = 0; i < NO_CH; i++) begin
            sh_shr[i]       = sh[i] >> BW_OUT;
            bus.data_out[i] = sh[i][BW_OUT-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sh     <= '0;
            cnt    <= '0;
            hb     <= '0;
            hb_vld <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                sh    <= bus.data_in;
                cnt   <= '0;
                state <= SHIFT;
            end
        end else if (advance && last_chunk) begin
            // Buffered word wins over a fresh one; rdy_in is low whenever hb is full anyway.
            if (hb_vld) begin
                sh     <= hb;
                cnt    <= '0;
                hb_vld <= 1'b0;
            end else if (accept) begin
                sh  <= bus.data_in;
                cnt <= '0;
            end else begin
                sh    <= sh_shr;
                cnt   <= '0;
                state <= IDLE;
            end
        end else begin
            if (advance) begin
                sh  <= sh_shr;
                cnt <= cnt + CNTR_BW'(1);
            end
            if (accept) begin
                hb     <= bus.data_in;
                hb_vld <= 1'b1;
            end
        end
    end
endmodule
